mul_div_secuencial: RTL and testbench

Iterative multiply/divide unit placed directly downstream of `Banco_Registros`. Consumes the two read operands (`Info_A`, `Info_B`) plus the destination address, computes over WIDTH cycles with a shift-add or shift-subtract datapath, and returns the result through a write-back port (`Result`, `Add_Dest`, `Write_En`). That port drives the register file's `Write_Data`, `Add_Dest` and `Write_En` inputs. A Start/Busy/Done handshake lets the control unit stall while an operation is in flight.

---
 rtl/mul_div_secuencial_pkg.sv | 28 ++
 rtl/mul_div_paso.sv | 35 +++
 rtl/mul_div_secuencial.sv | 144 ++++++++++++++
 tb/tb_mul_div_secuencial.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mul_div_secuencial_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation select,
// FSM state codes and the datapath mode derived from the operation.
package mul_div_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_e;

  // Op[1] splits multiply from divide; Op[0] picks the high/low accumulator half.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_takes_high(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_paso.sv
// One combinational iteration of the shift-add multiplier or the restoring
// divider, operating on the 2*WIDTH-bit accumulator.
module mul_div_paso
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               mode_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             borrow;

  always_comb begin
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? b_i : {WIDTH{1'b0}})};

    // Partial remainder stays below B, so after the shift it fits in WIDTH+1
    // bits and the difference, when non-negative, fits in WIDTH bits.
    rem_sh  = acc_i[2*WIDTH-1:WIDTH-1];
    borrow  = (rem_sh < {1'b0, b_i});
    rem_sub = rem_sh[WIDTH-1:0] - b_i;

    if (mode_i == 1'(MODE_DIV)) begin
      acc_o = {(borrow ? rem_sh[WIDTH-1:0] : rem_sub), acc_i[WIDTH-2:0], ~borrow};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_secuencial.sv
// Iterative MUL/MULHU/DIVU/REMU unit with register-file write-back port.
// Optional MULDIV_DIV0_FAST_EN: divide by zero skips the RUN iterations.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for Start; operands and destination latched on accept
// RUN     | one datapath iteration per cycle, counter 0..WIDTH-1
// DONE    | result selected from accumulator, Done/Write_En issued next
module mul_div_secuencial
  import mul_div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  Info_A,
  input  logic [WIDTH-1:0]  Info_B,
  input  logic [ADDR_W-1:0] Add_Dest_In,
  output logic              Busy,
  output logic              Done,
  output logic [WIDTH-1:0]  Result,
  output logic [ADDR_W-1:0] Add_Dest,
  output logic              Write_En
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0]  dest_q, dest_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               we_q, we_d;

  logic [2*WIDTH-1:0] acc_step;
  logic               fast_div0;

  mul_div_paso #(
    .WIDTH(WIDTH)
  ) u_paso (
    .acc_i (acc_q),
    .b_i   (b_q),
    .mode_i(op_is_div(op_q)),
    .acc_o (acc_step)
  );

`ifdef MULDIV_DIV0_FAST_EN
  assign fast_div0 = op_is_div(Op) && (Info_B == {WIDTH{1'b0}});
`else
  assign fast_div0 = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    acc_d    = acc_q;
    dest_d   = dest_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    we_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d   = Op;
          b_d    = Info_B;
          dest_d = Add_Dest_In;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (fast_div0) begin
            // Preload the final divide-by-zero image: remainder = A, quotient = all ones.
            acc_d   = {Info_A, {WIDTH{1'b1}}};
            state_d = ST_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, Info_A};
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = op_takes_high(op_q) ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
        done_d   = 1'b1;
        we_d     = (dest_q != {ADDR_W{1'b0}});
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      b_q      <= '0;
      acc_q    <= '0;
      dest_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Result   = result_q;
  assign Add_Dest = dest_q;
  assign Write_En = we_q;

endmodule

// File: tb/tb_mul_div_secuencial.sv
// Scoreboard bench for mul_div_secuencial: driver queues hand-computed
// results, a negedge monitor pops and checks them whenever Done pulses.
module tb_mul_div_secuencial;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] Info_A = '0;
  logic [31:0] Info_B = '0;
  logic [4:0]  Add_Dest_In = '0;
  logic        Busy, Done, Write_En;
  logic [31:0] Result;
  logic [4:0]  Add_Dest;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        we;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   ndone = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  logic prev_done = 1'b0;

`ifdef MULDIV_DIV0_FAST_EN
  localparam int LAT_DIV0 = 1;
`else
  localparam int LAT_DIV0 = 33;
`endif

  mul_div_secuencial #(.WIDTH(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Op(Op),
    .Info_A(Info_A), .Info_B(Info_B), .Add_Dest_In(Add_Dest_In),
    .Busy(Busy), .Done(Done), .Result(Result), .Add_Dest(Add_Dest), .Write_En(Write_En)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (RST_N) begin
      if (prev_done) begin
        chk("done_one_cycle", {63'd0, Done}, 64'd0);
        chk("we_one_cycle", {63'd0, Write_En}, 64'd0);
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_done: got Result 0x%0h expected no Done", Result);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", {32'd0, Result}, {32'd0, e.res});
          chk("add_dest", {59'd0, Add_Dest}, {59'd0, e.dest});
          chk("write_en", {63'd0, Write_En}, {63'd0, e.we});
          chk("latency", 64'(cyc - start_cyc), 64'(e.lat));
        end
        ndone++;
      end
      prev_done <= Done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] res, input int lat, input int poke);
    int n0;
    exp_t e;
    e.res = res; e.dest = d; e.we = (d != 5'd0); e.lat = lat;
    exp_q.push_back(e);
    @(negedge CLK);
    Op = op; Info_A = a; Info_B = b; Add_Dest_In = d; Start = 1'b1;
    n0 = ndone;
    @(posedge CLK);
    #1;
    start_cyc = cyc;
    Start = 1'b0;
    Info_A = $urandom; Info_B = $urandom; Op = 2'($urandom); Add_Dest_In = 5'($urandom);
    for (int i = 0; i < 60 && ndone == n0; i++) begin
      @(negedge CLK);
      if (i == poke) Start = 1'b1;
      if (i == poke + 1) begin
        Start = 1'b0;
        chk("busy_mid_run", {63'd0, Busy}, 64'd1);
      end
    end
    Start = 1'b0;
    if (ndone == n0) begin
      nchk++;
      nfail++;
      $display("FAIL done_timeout: got no Done expected Done within 60 cycles");
    end
  endtask

  initial begin
    #1;
    chk("rst_busy", {63'd0, Busy}, 64'd0);
    chk("rst_done", {63'd0, Done}, 64'd0);
    chk("rst_result", {32'd0, Result}, 64'd0);
    chk("rst_we", {63'd0, Write_En}, 64'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;

    run_op(2'b00, 32'd7, 32'd6, 5'd3, 32'd42, 33, -5);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 33, -5);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0001, 33, -5);
    run_op(2'b10, 32'd100, 32'd7, 5'd6, 32'd14, 33, 5);
    run_op(2'b11, 32'd100, 32'd7, 5'd7, 32'd2, 33, -5);
    run_op(2'b10, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, LAT_DIV0, -5);
    run_op(2'b11, 32'd5, 32'd0, 5'd9, 32'd5, LAT_DIV0, -5);
    run_op(2'b00, 32'd3, 32'd3, 5'd0, 32'd9, 33, -5);

    // Abort an operation mid-RUN; nothing is queued for it.
    @(negedge CLK);
    Op = 2'b00; Info_A = 32'd5; Info_B = 32'd5; Add_Dest_In = 5'd7; Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (10) @(negedge CLK);
    chk("busy_before_abort", {63'd0, Busy}, 64'd1);
    RST_N = 1'b0;
    #1;
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    chk("abort_done", {63'd0, Done}, 64'd0);
    chk("abort_we", {63'd0, Write_En}, 64'd0);
    chk("abort_result", {32'd0, Result}, 64'd0);
    chk("abort_add_dest", {59'd0, Add_Dest}, 64'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);

    run_op(2'b00, 32'd2, 32'd2, 5'd10, 32'd4, 33, -5);

    repeat (5) @(negedge CLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
